// File: rtl/fifo_rd_stream_adapter_if.sv
// Bundles the FIFO read port and the outgoing valid/ready stream seen by the
// read-side drain stage. The master side belongs to the adapter. The slave
// side belongs to the FIFO plus the downstream consumer.
interface fifo_rd_stream_adapter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_flush;
    logic                  i_fifo_empty;
    logic [DATA_WIDTH-1:0] i_fifo_rd_data;
    logic                  o_fifo_rd_en;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  i_ready;
    logic [1:0]            o_level;

    modport master (
        input  i_flush,
        input  i_fifo_empty,
        input  i_fifo_rd_data,
        input  i_ready,
        output o_fifo_rd_en,
        output o_valid,
        output o_data,
        output o_level
    );

    modport slave (
        output i_flush,
        output i_fifo_empty,
        output i_fifo_rd_data,
        output i_ready,
        input  o_fifo_rd_en,
        input  o_valid,
        input  o_data,
        input  o_level
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side drain stage for the async FIFO. It turns the FIFO's
// rd_en/empty/rd_data port, which has one cycle of read latency, into a
// valid/ready stream. A two-entry buffer absorbs the read latency, so the
// stream can move one word per cycle and still honour backpressure.
module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      RST,
    fifo_rd_stream_adapter_if.master  bus
);

    logic [1:0]            level_q;
    logic [1:0]            level_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] head_d;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [DATA_WIDTH-1:0] tail_d;
    logic                  valid;
    logic                  pop;
    logic                  push;
    logic                  rd_en;
    logic [1:0]            occ;

    assign valid = (level_q != 2'd0);
    assign pop   = valid & bus.i_ready;
    assign push  = inflight_q;
    assign occ   = level_q + {1'b0, inflight_q};

    // A read is issued only when its word is sure to have room on arrival.
    // Room exists if the buffered words plus the in-flight word total fewer
    // than two. Room also exists if the total is two and a word leaves this cycle.
    assign rd_en = RST & ~bus.i_fifo_empty & ~bus.i_flush &
                   ((occ < 2'd2) | ((occ == 2'd2) & pop));

    assign bus.o_fifo_rd_en = rd_en;
    assign bus.o_valid      = valid;
    assign bus.o_data       = head_q;
    assign bus.o_level      = level_q;

    // Next buffer contents. Arriving words go to the tail and leaving words
    // come from the head. A flush empties the buffer no matter what else happens.
    always_comb begin
        level_d = level_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (bus.i_flush) begin
            level_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (level_q == 2'd0) begin
                        head_d = bus.i_fifo_rd_data;
                    end else begin
                        tail_d = bus.i_fifo_rd_data;
                    end
                    level_d = level_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    level_d = level_q - 2'd1;
                end
                2'b11: begin
                    if (level_q == 2'd1) begin
                        head_d = bus.i_fifo_rd_data;
                    end else begin
                        head_d = tail_q;
                        tail_d = bus.i_fifo_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Buffer registers and the in-flight flag. A read issued during or just
    // before a flush is dropped, because the flush forces rd_en low and the
    // next-state logic ignores the arriving word.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            level_q    <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            level_q    <= level_d;
            inflight_q <= rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Testbench for fifo_rd_stream_adapter. A small behavioural model stands in
// for the async FIFO read port. Every word written into that model is also
// queued as an expected stream word. A separate monitor compares each word
// the adapter presents against the head of that queue.
module tb_fifo_rd_stream_adapter;

    logic clk;
    logic RST;

    fifo_rd_stream_adapter_if #(.DATA_WIDTH(8)) bus ();

    fifo_rd_stream_adapter #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    int        num_checks = 0;
    int        num_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fifo_mem [0:255];
    int        wr_cnt = 0;
    int        rd_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.i_fifo_empty = (wr_cnt == rd_cnt);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Waits for the next rising edge, then drives ready and flush just after it.
    task automatic applyStimulus(input logic ready, input logic flush);
        @(posedge clk);
        #1;
        bus.i_ready = ready;
        bus.i_flush = flush;
    endtask

    // Writes one word into the FIFO model and records it as an expected stream word.
    task automatic pushWord(input logic [7:0] d);
        fifo_mem[wr_cnt[7:0]] = d;
        wr_cnt = wr_cnt + 1;
        exp_q.push_back(d);
    endtask

    task automatic waitValid(input int budget);
        int c;
        c = 0;
        @(negedge clk);
        while (!bus.o_valid && c < budget) begin
            @(negedge clk);
            c++;
        end
        checkOutput("wait_valid", {31'b0, bus.o_valid}, 32'd1);
    endtask

    task automatic waitDrain(input int budget);
        int c;
        c = 0;
        applyStimulus(1'b1, 1'b0);
        while ((exp_q.size() != 0 || !bus.i_fifo_empty) && c < budget) begin
            applyStimulus(1'b1, 1'b0);
            c++;
        end
        checkOutput("drain_pending", exp_q.size(), 32'd0);
        @(negedge clk);
        checkOutput("drain_level", {30'b0, bus.o_level}, 32'd0);
    endtask

    // FIFO read-port model. It has one cycle of read latency and is cleared by the shared reset.
    always @(posedge clk or negedge RST) begin
        if (!RST) begin
            rd_cnt             <= wr_cnt;
            bus.i_fifo_rd_data <= '0;
        end else if (bus.o_fifo_rd_en) begin
            checkOutput("no_read_when_empty", {31'b0, bus.i_fifo_empty}, 32'd0);
            bus.i_fifo_rd_data <= fifo_mem[rd_cnt[7:0]];
            rd_cnt             <= rd_cnt + 1;
        end
    end

    // Monitor. Any word on the stream must match the oldest expected word.
    // The word leaves the queue only when the handshake completes. Flush
    // cycles are skipped because the flush cancels the pop.
    always @(negedge clk) begin
        if (RST === 1'b1) begin
            checkOutput("level_bound", {31'b0, (bus.o_level <= 2'd2)}, 32'd1);
            if (bus.o_valid && !bus.i_flush) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", {24'b0, bus.o_data}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("stream_data", {24'b0, bus.o_data}, {24'b0, exp_q[0]});
                    if (bus.i_ready) exp_q.delete(0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST         = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_flush = 1'b0;

        // Reset with the FIFO holding a word. No read may be issued and all outputs stay clear.
        repeat (2) @(posedge clk);
        #1;
        fifo_mem[wr_cnt[7:0]] = 8'h5A;
        wr_cnt = wr_cnt + 1;
        @(negedge clk);
        checkOutput("reset_rd_en", {31'b0, bus.o_fifo_rd_en}, 32'd0);
        checkOutput("reset_valid", {31'b0, bus.o_valid}, 32'd0);
        checkOutput("reset_data", {24'b0, bus.o_data}, 32'd0);
        checkOutput("reset_level", {30'b0, bus.o_level}, 32'd0);
        @(posedge clk);
        #1;
        RST = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_rd_en", {31'b0, bus.o_fifo_rd_en}, 32'd0);
        checkOutput("post_reset_valid", {31'b0, bus.o_valid}, 32'd0);

        // Latency: a single word is read at once and appears two cycles later for one cycle.
        applyStimulus(1'b1, 1'b0);
        pushWord(8'hA5);
        @(negedge clk);
        checkOutput("lat_rd_en_c0", {31'b0, bus.o_fifo_rd_en}, 32'd1);
        checkOutput("lat_valid_c0", {31'b0, bus.o_valid}, 32'd0);
        @(negedge clk);
        checkOutput("lat_rd_en_c1", {31'b0, bus.o_fifo_rd_en}, 32'd0);
        checkOutput("lat_valid_c1", {31'b0, bus.o_valid}, 32'd0);
        @(negedge clk);
        checkOutput("lat_valid_c2", {31'b0, bus.o_valid}, 32'd1);
        checkOutput("lat_data_c2", {24'b0, bus.o_data}, 32'hA5);
        @(negedge clk);
        checkOutput("lat_valid_c3", {31'b0, bus.o_valid}, 32'd0);

        // Streaming: 32 words come out on consecutive cycles once the first appears.
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 32; i++) pushWord(i[7:0]);
        waitValid(8);
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            checkOutput("stream_no_gap", {31'b0, bus.o_valid}, 32'd1);
        end
        waitDrain(50);

        // Backpressure: the buffer fills to two and reads stop. The monitor
        // checks that the presented word stays equal to the oldest expected word.
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) pushWord(8'h60 + i[7:0]);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_level_full", {30'b0, bus.o_level}, 32'd2);
        checkOutput("bp_rd_en_blocked", {31'b0, bus.o_fifo_rd_en}, 32'd0);
        checkOutput("bp_valid_held", {31'b0, bus.o_valid}, 32'd1);
        waitDrain(50);

        // Flush with a full buffer. Words 0x40 and 0x41 are dropped, so 0x42 is the next word out.
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) pushWord(8'h40 + i[7:0]);
        repeat (6) applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fl1_level_before", {30'b0, bus.o_level}, 32'd2);
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        checkOutput("fl1_no_rd_in_flush", {31'b0, bus.o_fifo_rd_en}, 32'd0);
        applyStimulus(1'b1, 1'b0);
        exp_q.delete(0);
        exp_q.delete(0);
        @(negedge clk);
        checkOutput("fl1_valid_cleared", {31'b0, bus.o_valid}, 32'd0);
        checkOutput("fl1_level_cleared", {30'b0, bus.o_level}, 32'd0);
        waitDrain(50);

        // Flush mid-stream. Words 0x50..0x52 have already been accepted. In
        // the flush cycle 0x53 is buffered and 0x54 is in flight. Both are dropped.
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) pushWord(8'h50 + i[7:0]);
        waitValid(8);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        checkOutput("fl2_level_in_flush", {30'b0, bus.o_level}, 32'd1);
        checkOutput("fl2_head_in_flush", {24'b0, bus.o_data}, 32'h53);
        checkOutput("fl2_no_rd_in_flush", {31'b0, bus.o_fifo_rd_en}, 32'd0);
        applyStimulus(1'b1, 1'b0);
        exp_q.delete(0);
        exp_q.delete(0);
        @(negedge clk);
        checkOutput("fl2_valid_cleared", {31'b0, bus.o_valid}, 32'd0);
        waitDrain(50);

        // Random ready and random FIFO fill. The scoreboard must match exactly.
        for (int i = 0; i < 150; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) pushWord(8'($urandom));
        end
        waitDrain(400);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
